spi_transfer_controller: RTL and testbench

//  Sequences one SPI mode-0 (CPOL=0, CPHA=0) master transfer at a time, MSB first.

---
 rtl/spi_transfer_controller.sv | 162 ++++++++++++++++
 tb/tb_spi_transfer_controller.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transfer_controller.sv
// SPI mode-0 master transfer sequencer.
// Runs one MSB-first transfer at a time. It owns the divider load and the
// enable of an external serial clock generator, and reacts to that
// generator's rising/falling strobes. ss_n is held low across chained
// transfers and is framed by setup/hold guard cycles.
`timescale 1ns/1ps

module spi_transfer_controller #(
    parameter int DATA_W   = 8,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_div_valid_i,
    input  logic [7:0]        cfg_div_i,
    output logic              cfg_ready_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic              req_last_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              ss_n_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              gen_en_o,
    output logic              gen_div_valid_o,
    output logic [7:0]        gen_div_o,
    input  logic              gen_rising_i,
    input  logic              gen_falling_i
);

    localparam int GUARD_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int GUARD_W   = $clog2(GUARD_MAX + 1);
    localparam int BIT_W     = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD
    } state_t;

    state_t              state_q;
    logic [GUARD_W-1:0]  guard_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   tx_shreg_q;
    logic [DATA_W-1:0]   rx_shreg_q;
    logic                last_q;
    logic                ss_n_q;
    logic                mosi_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                gen_div_valid_q;
    logic [7:0]          gen_div_q;
    logic                final_fall;

    // The last falling strobe of a word: stop the generator in that same
    // cycle so it never produces a further edge.
    assign final_fall      = gen_falling_i && (bit_cnt_q == BIT_W'(DATA_W - 1));
    assign gen_en_o        = (state_q == ST_SHIFT) && !final_fall;
    assign cfg_ready_o     = (state_q == ST_IDLE);
    assign req_ready_o     = ((state_q == ST_IDLE) && !cfg_div_valid_i) || (state_q == ST_GAP);
    assign busy_o          = (state_q != ST_IDLE);
    assign ss_n_o          = ss_n_q;
    assign mosi_o          = mosi_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign gen_div_valid_o = gen_div_valid_q;
    assign gen_div_o       = gen_div_q;

    // Transfer sequencer: state, guard/bit counters, shift registers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            guard_cnt_q     <= '0;
            bit_cnt_q       <= '0;
            tx_shreg_q      <= '0;
            rx_shreg_q      <= '0;
            last_q          <= 1'b0;
            ss_n_q          <= 1'b1;
            mosi_q          <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            gen_div_valid_q <= 1'b0;
            gen_div_q       <= '0;
        end else begin
            gen_div_valid_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_div_valid_i) begin
                        // A divider load wins over a pending request this cycle.
                        gen_div_q       <= cfg_div_i;
                        gen_div_valid_q <= 1'b1;
                    end else if (req_valid_i) begin
                        tx_shreg_q  <= req_data_i;
                        mosi_q      <= req_data_i[DATA_W-1];
                        rx_shreg_q  <= '0;
                        bit_cnt_q   <= '0;
                        last_q      <= req_last_i;
                        ss_n_q      <= 1'b0;
                        guard_cnt_q <= '0;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (guard_cnt_q == GUARD_W'(SS_SETUP - 1)) begin
                        guard_cnt_q <= '0;
                        state_q     <= ST_SHIFT;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (gen_rising_i) begin
                        rx_shreg_q <= {rx_shreg_q[DATA_W-2:0], miso_i};
                    end else if (gen_falling_i) begin
                        if (final_fall) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rx_shreg_q;
                            mosi_q      <= 1'b0;
                            guard_cnt_q <= '0;
                            state_q     <= last_q ? ST_HOLD : ST_GAP;
                        end else begin
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            mosi_q     <= tx_shreg_q[DATA_W-2];
                            tx_shreg_q <= {tx_shreg_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                ST_GAP: begin
                    // Chained word: ss_n is already low, so skip the setup guard.
                    if (req_valid_i) begin
                        tx_shreg_q <= req_data_i;
                        mosi_q     <= req_data_i[DATA_W-1];
                        rx_shreg_q <= '0;
                        bit_cnt_q  <= '0;
                        last_q     <= req_last_i;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (guard_cnt_q == GUARD_W'(SS_HOLD - 1)) begin
                        guard_cnt_q <= '0;
                        ss_n_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Directed bench for spi_transfer_controller with a behavioural clock generator.
`timescale 1ns/1ps

module tb_spi_transfer_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_div_valid = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'd0;
    logic       req_last = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       gen_en;
    logic       gen_div_valid;
    logic [7:0] gen_div;
    logic       gen_rising;
    logic       gen_falling;

    logic       miso_loop = 1'b1;
    logic       miso_fix = 1'b0;
    logic       sck;
    logic [7:0] gcnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // monitor counters (only written by the monitor process)
    int rise_cnt = 0;
    int fall_cnt = 0;
    int rsp_cnt = 0;
    int gdv_cnt = 0;
    int viol_cnt = 0;
    int ss_hi_cnt = 0;
    int last_rise_cyc = 0;
    int last_fall_cyc = 0;
    int last_hp = 0;
    logic ss_prev = 1'b1;
    logic chain_mon = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign miso = miso_loop ? mosi : miso_fix;

    spi_transfer_controller #(.DATA_W(8), .SS_SETUP(2), .SS_HOLD(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_div_valid_i (cfg_div_valid),
        .cfg_div_i       (cfg_div),
        .cfg_ready_o     (cfg_ready),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_data_i      (req_data),
        .req_last_i      (req_last),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .busy_o          (busy),
        .ss_n_o          (ss_n),
        .mosi_o          (mosi),
        .miso_i          (miso),
        .gen_en_o        (gen_en),
        .gen_div_valid_o (gen_div_valid),
        .gen_div_o       (gen_div),
        .gen_rising_i    (gen_rising),
        .gen_falling_i   (gen_falling)
    );

    // Serial clock generator model: sck toggles every gen_div+1 enabled cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck         <= 1'b0;
            gcnt        <= 8'd0;
            gen_rising  <= 1'b0;
            gen_falling <= 1'b0;
        end else begin
            gen_rising  <= 1'b0;
            gen_falling <= 1'b0;
            if (!gen_en) begin
                gcnt <= 8'd0;
            end else if (gcnt == gen_div) begin
                gcnt        <= 8'd0;
                sck         <= ~sck;
                gen_rising  <= ~sck;
                gen_falling <= sck;
            end else begin
                gcnt <= gcnt + 8'd1;
            end
        end
    end

    // Monitor: strobe counts, half-period, ss_n toggling only while sck is low.
    always @(negedge clk) begin
        if (gen_rising) begin
            rise_cnt      <= rise_cnt + 1;
            last_rise_cyc <= cyc;
        end
        if (gen_falling) begin
            fall_cnt      <= fall_cnt + 1;
            last_fall_cyc <= cyc;
            last_hp       <= cyc - last_rise_cyc;
        end
        if (rsp_valid)     rsp_cnt <= rsp_cnt + 1;
        if (gen_div_valid) gdv_cnt <= gdv_cnt + 1;
        if (ss_n !== ss_prev && sck) viol_cnt <= viol_cnt + 1;
        if (chain_mon && ss_n) ss_hi_cnt <= ss_hi_cnt + 1;
        ss_prev <= ss_n;
    end

    task automatic do_cfg(input logic [7:0] d);
        @(posedge clk); #1;
        cfg_div_valid = 1'b1;
        cfg_div = d;
        @(posedge clk); #1;
        cfg_div_valid = 1'b0;
    endtask

    task automatic do_req(input logic [7:0] d, input logic l, output int hs);
        hs = -1000;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data = d;
        req_last = l;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                hs = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output logic [7:0] d, output int rc);
        rc = -1;
        d = 8'hxx;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rc = cyc;
                d = rsp_data;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [9:0] got;
        logic [9:0] exp;
        got = {ss_n, mosi, rsp_valid, gen_en, gen_div_valid, busy, cfg_ready, req_ready, 2'b00};
        exp = 10'b1_0_0_0_0_0_1_1_00;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_flags got=%b expected=%b", got, exp);
        end
        vectors++;
        if (rsp_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rsp_data got=%h expected=00", rsp_data);
        end
        vectors++;
        if (gen_div !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_gen_div got=%h expected=00", gen_div);
        end
    endtask

    task automatic test_config_single;
        int hs, rc;
        logic [7:0] d;
        @(posedge clk); #1;
        cfg_div_valid = 1'b1;
        cfg_div = 8'd0;
        @(posedge clk); #1;
        cfg_div_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (gen_div_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_pulse got=%b expected=1", gen_div_valid);
        end
        @(negedge clk);
        vectors++;
        if (gen_div_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_pulse_single got=%b expected=0", gen_div_valid);
        end
        miso_loop = 1'b1;
        do_req(8'hA5, 1'b1, hs);
        wait_rsp(200, d, rc);
        $display("xfer data=a5 rsp=%h latency=%0d", d, rc - hs);
        vectors++;
        if (d !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_data got=%h expected=a5", d);
        end
        vectors++;
        if (rc - hs !== 20) begin
            miscompares++;
            $display("FAIL single_latency got=%0d expected=20", rc - hs);
        end
        vectors++;
        if (last_fall_cyc !== rc - 1) begin
            miscompares++;
            $display("FAIL single_last_fall got=%0d expected=%0d", last_fall_cyc, rc - 1);
        end
        @(negedge clk);
        vectors++;
        if (ss_n !== 1'b0) begin
            miscompares++;
            $display("FAIL ss_hold_low got=%b expected=0", ss_n);
        end
        @(negedge clk);
        vectors++;
        if (ss_n !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ss_release got ss_n=%b busy=%b expected ss_n=1 busy=0", ss_n, busy);
        end
    endtask

    task automatic test_divider3;
        int hs, rc;
        logic [7:0] d;
        do_cfg(8'd3);
        miso_loop = 1'b0;
        miso_fix = 1'b1;
        do_req(8'h3C, 1'b1, hs);
        wait_rsp(300, d, rc);
        $display("xfer data=3c rsp=%h latency=%0d", d, rc - hs);
        vectors++;
        if (d !== 8'hFF) begin
            miscompares++;
            $display("FAIL div3_data got=%h expected=ff", d);
        end
        vectors++;
        if (rc - hs !== 68) begin
            miscompares++;
            $display("FAIL div3_latency got=%0d expected=68", rc - hs);
        end
        vectors++;
        if (last_hp !== 4) begin
            miscompares++;
            $display("FAIL div3_half_period got=%0d expected=4", last_hp);
        end
        miso_loop = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_back_to_back;
        int hs, rc, r0, s0, p0;
        logic [7:0] d;
        do_cfg(8'd0);
        #1;
        r0 = rise_cnt;
        s0 = ss_hi_cnt;
        p0 = rsp_cnt;
        do_req(8'h12, 1'b0, hs);
        chain_mon = 1'b1;
        wait_rsp(200, d, rc);
        $display("xfer data=12 rsp=%h last=0", d);
        vectors++;
        if (d !== 8'h12) begin
            miscompares++;
            $display("FAIL chain_first_data got=%h expected=12", d);
        end
        do_req(8'h34, 1'b1, hs);
        wait_rsp(200, d, rc);
        chain_mon = 1'b0;
        $display("xfer data=34 rsp=%h last=1", d);
        vectors++;
        if (d !== 8'h34) begin
            miscompares++;
            $display("FAIL chain_second_data got=%h expected=34", d);
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (ss_hi_cnt - s0 !== 0) begin
            miscompares++;
            $display("FAIL chain_ss_gap got=%0d high cycles expected=0", ss_hi_cnt - s0);
        end
        vectors++;
        if (rise_cnt - r0 !== 16 || rsp_cnt - p0 !== 2) begin
            miscompares++;
            $display("FAIL chain_counts got rise=%0d rsp=%0d expected rise=16 rsp=2",
                     rise_cnt - r0, rsp_cnt - p0);
        end
    endtask

    task automatic test_config_contention;
        int hs, rc, g0;
        logic [7:0] d;
        repeat (3) @(posedge clk);
        #1;
        cfg_div_valid = 1'b1;
        cfg_div = 8'd1;
        req_valid = 1'b1;
        req_data = 8'h5A;
        req_last = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL contention_ready got req_ready=%b cfg_ready=%b expected 0/1", req_ready, cfg_ready);
        end
        @(posedge clk); #1;
        cfg_div_valid = 1'b0;
        @(negedge clk);
        hs = cyc;
        vectors++;
        if (gen_div_valid !== 1'b1 || gen_div !== 8'd1 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL contention_load got gdv=%b div=%0d req_ready=%b expected 1/1/1",
                     gen_div_valid, gen_div, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        g0 = gdv_cnt;
        cfg_div_valid = 1'b1;
        cfg_div = 8'd5;
        @(posedge clk); #1;
        cfg_div_valid = 1'b0;
        wait_rsp(200, d, rc);
        $display("xfer data=5a rsp=%h latency=%0d", d, rc - hs);
        vectors++;
        if (d !== 8'h5A || rc - hs !== 36) begin
            miscompares++;
            $display("FAIL contention_xfer got data=%h lat=%0d expected data=5a lat=36", d, rc - hs);
        end
        vectors++;
        if (gdv_cnt - g0 !== 0 || gen_div !== 8'd1) begin
            miscompares++;
            $display("FAIL busy_cfg_ignored got pulses=%0d div=%0d expected 0/1", gdv_cnt - g0, gen_div);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid_shift;
        int hs, rc, f0, p0;
        logic [7:0] d;
        bit reached;
        #1;
        f0 = fall_cnt;
        reached = 1'b0;
        do_req(8'hC3, 1'b1, hs);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (fall_cnt - f0 >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL abort_reach_bit3 got falls=%0d expected 3", fall_cnt - f0);
        end
        p0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ss_n !== 1'b1 || gen_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state got ss_n=%b gen_en=%b busy=%b expected 1/0/0", ss_n, gen_en, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rsp_cnt - p0 !== 0) begin
            miscompares++;
            $display("FAIL abort_no_rsp got pulses=%0d expected 0", rsp_cnt - p0);
        end
        do_req(8'h96, 1'b1, hs);
        wait_rsp(200, d, rc);
        $display("xfer data=96 rsp=%h latency=%0d after reset", d, rc - hs);
        vectors++;
        if (d !== 8'h96 || rc - hs !== 20) begin
            miscompares++;
            $display("FAIL post_reset_xfer got data=%h lat=%0d expected data=96 lat=20", d, rc - hs);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_edge_count;
        int hs, rc, r0, f0, v0;
        logic [7:0] d;
        do_cfg(8'd2);
        #1;
        r0 = rise_cnt;
        f0 = fall_cnt;
        v0 = viol_cnt;
        do_req(8'h81, 1'b1, hs);
        wait_rsp(300, d, rc);
        $display("xfer data=81 rsp=%h latency=%0d", d, rc - hs);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (d !== 8'h81 || rc - hs !== 52) begin
            miscompares++;
            $display("FAIL edge_xfer got data=%h lat=%0d expected data=81 lat=52", d, rc - hs);
        end
        vectors++;
        if (rise_cnt - r0 !== 8 || fall_cnt - f0 !== 8) begin
            miscompares++;
            $display("FAIL edge_count got rise=%0d fall=%0d expected 8/8", rise_cnt - r0, fall_cnt - f0);
        end
        vectors++;
        if (viol_cnt !== 0 || viol_cnt - v0 !== 0) begin
            miscompares++;
            $display("FAIL ss_vs_sck got violations=%0d expected 0", viol_cnt);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_config_single();
        test_divider3();
        test_back_to_back();
        test_config_contention();
        test_reset_mid_shift();
        test_edge_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
